uart_hex_printer: RTL

Upstream feeder for the UART transmitter. Accepts one binary word per valid/ready handshake and emits it as uppercase ASCII hex, MS nibble first, terminated by CR LF. Drives the transmitter's data/send inputs and paces itself on the transmitter's busy output. Used for debug printing of counters/status words over the 115200-baud link.

---
 rtl/uart_pkg.sv | 29 ++
 rtl/hex_nibble_to_ascii.sv | 17 +
 rtl/uart_hex_printer.sv | 120 ++++++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART debug path: ASCII codes, printer FSM states, bit timing.
// Honours UART_HEX_PREFIX_EN (adds a "0x" prefix to each printed line).
package uart_pkg;

  localparam int CLKS_PER_BIT = 234;

  localparam logic [7:0] CHR_0  = 8'h30;
  localparam logic [7:0] CHR_A  = 8'h41;
  localparam logic [7:0] CHR_X  = 8'h78;
  localparam logic [7:0] CHR_CR = 8'h0D;
  localparam logic [7:0] CHR_LF = 8'h0A;

  typedef enum logic [1:0] {
    IDLE,
    SEND,
    ACK,
    DONE
  } state_t;

  // Bytes emitted for one word, including the line terminator.
  function automatic int line_bytes(input int nibbles);
`ifdef UART_HEX_PREFIX_EN
    return nibbles + 4;
`else
    return nibbles + 2;
`endif
  endfunction

endpackage

// File: rtl/hex_nibble_to_ascii.sv
// Combinational 4-bit to uppercase ASCII hex digit encoder.
module hex_nibble_to_ascii
  import uart_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [7:0] ascii
);

  always_comb begin
    if (nibble < 4'd10) begin
      ascii = CHR_0 + {4'h0, nibble};
    end else begin
      ascii = CHR_A - 8'd10 + {4'h0, nibble};
    end
  end

endmodule

// File: rtl/uart_hex_printer.sv
// Prints one word per handshake as uppercase hex plus CR LF, paced by the transmitter busy flag.
// Define UART_HEX_PREFIX_EN to start every line with "0x".
module uart_hex_printer
  import uart_pkg::*;
#(
  parameter int NIBBLES = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [4*NIBBLES-1:0] value,
  input  logic                 value_valid,
  output logic                 value_ready,
  output logic [7:0]           tx_data,
  output logic                 tx_send,
  input  logic                 tx_busy,
  output logic                 active
);

  localparam int W     = 4 * NIBBLES;
  localparam int CW    = $clog2(NIBBLES + 5);
  localparam int TOTAL = line_bytes(NIBBLES);
`ifdef UART_HEX_PREFIX_EN
  localparam int DIG0  = 2;
`else
  localparam int DIG0  = 0;
`endif
  localparam logic [CW-1:0] LAST_IDX = CW'(TOTAL - 1);
  localparam logic [CW-1:0] CR_IDX   = CW'(DIG0 + NIBBLES);

  state_t        state;
  logic [W-1:0]  shift_reg;
  logic [CW-1:0] byte_cnt;
  logic [7:0]    digit_ascii;
  logic [7:0]    cur_byte;
  logic          cur_is_digit;

  hex_nibble_to_ascii u_hex (
    .nibble (shift_reg[W-1 -: 4]),
    .ascii  (digit_ascii)
  );

  // The top nibble of the shift register is always the next digit to print.
  always_comb begin
    cur_byte     = CHR_LF;
    cur_is_digit = 1'b0;
`ifdef UART_HEX_PREFIX_EN
    if (byte_cnt == CW'(0)) begin
      cur_byte = CHR_0;
    end else if (byte_cnt == CW'(1)) begin
      cur_byte = CHR_X;
    end else if (byte_cnt < CR_IDX) begin
      cur_byte     = digit_ascii;
      cur_is_digit = 1'b1;
    end else if (byte_cnt == CR_IDX) begin
      cur_byte = CHR_CR;
    end
`else
    if (byte_cnt < CR_IDX) begin
      cur_byte     = digit_ascii;
      cur_is_digit = 1'b1;
    end else if (byte_cnt == CR_IDX) begin
      cur_byte = CHR_CR;
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      shift_reg   <= '0;
      byte_cnt    <= '0;
      value_ready <= 1'b1;
      tx_data     <= 8'h00;
      tx_send     <= 1'b0;
      active      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (value_valid && value_ready) begin
            shift_reg   <= value;
            byte_cnt    <= '0;
            active      <= 1'b1;
            value_ready <= 1'b0;
            state       <= SEND;
          end
        end
        SEND: begin
          if (!tx_busy) begin
            tx_data <= cur_byte;
            tx_send <= 1'b1;
            state   <= ACK;
          end
        end
        ACK: begin
          tx_send <= 1'b0;
          if (tx_busy) begin
            state <= DONE;
          end
        end
        DONE: begin
          if (!tx_busy) begin
            if (byte_cnt == LAST_IDX) begin
              active      <= 1'b0;
              value_ready <= 1'b1;
              state       <= IDLE;
            end else begin
              if (cur_is_digit) begin
                shift_reg <= shift_reg << 4;
              end
              byte_cnt <= byte_cnt + CW'(1);
              state    <= SEND;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
